// File: rtl/redn_seq.sv
// Sequential bitwise reduction (AND/OR/XOR/XNOR) of a WIDTH-bit operand,
// folding CHUNK bits per cycle through an IDLE -> RUN -> DONE state machine.
module redn_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both 1. in_ready is 1 only in IDLE, out_valid only in DONE, and y is
  // held stable in DONE until the consumer accepts it.

  localparam int CHUNK_S = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N       = (WIDTH / CHUNK_S < 1) ? 1 : WIDTH / CHUNK_S;
  localparam int CW      = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);
  localparam bit PARAM_OK = (WIDTH >= 1) && (CHUNK >= 1) && (CHUNK <= WIDTH) &&
                            ((WIDTH % CHUNK_S) == 0);

  if (!PARAM_OK) begin : g_bad_params
    $error("redn_seq: need WIDTH >= 1, 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  opnd;
  logic [1:0]        op;
  logic              acc;
  logic [CW-1:0]     k;
  logic [CHUNK_S-1:0] chunk;
  logic              fold;

  assign dbg_state = state;

  // XNOR folds as XOR; the inversion is applied once when the result is latched.
  always_comb begin
    chunk = CHUNK_S'(opnd >> (int'(k) * CHUNK_S));
    case (op)
      2'b00:   fold = acc & (&chunk);
      2'b01:   fold = acc | (|chunk);
      default: fold = acc ^ (^chunk);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opnd      <= '0;
      op        <= '0;
      acc       <= 1'b0;
      k         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd     <= a;
            op       <= mode;
            acc      <= (mode == 2'b00);
            k        <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc <= fold;
          k   <= k + CW'(1);
          if (k == CW'(N - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            y         <= (op == 2'b11) ? ~fold : fold;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            y         <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          y         <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_redn_seq.sv
// Bench for redn_seq: three instances (CHUNK 4, 1, 16) share one stimulus
// stream; a negedge monitor checks results and latency from an expected queue.
module tb_redn_seq;

  localparam int W = 16;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a         = '0;
  logic [1:0]   mode      = '0;

  logic [2:0] in_ready, out_valid, y, busy;
  logic [1:0] dbg [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat [3] = '{4, 16, 1};

  logic [0:0] exp_q [3][$];
  int         acc_q [3][$];
  bit         seen [3];
  bit         chk_idle [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  redn_seq #(.WIDTH(W), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .mode(mode), .out_valid(out_valid[0]), .out_ready(out_ready),
    .y(y[0]), .busy(busy[0]), .dbg_state(dbg[0])
  );
  redn_seq #(.WIDTH(W), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .mode(mode), .out_valid(out_valid[1]), .out_ready(out_ready),
    .y(y[1]), .busy(busy[1]), .dbg_state(dbg[1])
  );
  redn_seq #(.WIDTH(W), .CHUNK(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a), .mode(mode), .out_valid(out_valid[2]), .out_ready(out_ready),
    .y(y[2]), .busy(busy[2]), .dbg_state(dbg[2])
  );

  function automatic logic ref_red(input logic [W-1:0] v, input logic [1:0] m);
    case (m)
      2'b00:   return &v;
      2'b01:   return |v;
      2'b10:   return ^v;
      default: return ~^v;
    endcase
  endfunction

  // Monitor: result/latency on output, idle check the cycle after a handshake.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        seen[g]     = 1'b0;
        chk_idle[g] = 1'b0;
      end else begin
        if (chk_idle[g]) begin
          checks++;
          if (in_ready[g] !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_out[%0d] in_ready=%b want 1", g, in_ready[g]);
          end
          chk_idle[g] = 1'b0;
        end
        if (out_valid[g] !== 1'b1) begin
          checks++;
          if (y[g] !== 1'b0) begin
            errors++;
            $display("FAIL y_zero[%0d] y=%b want 0 while out_valid=%b", g, y[g], out_valid[g]);
          end
        end else begin
          checks++;
          if (busy[g] !== 1'b1 || in_ready[g] !== 1'b0 || dbg[g] !== 2'd2) begin
            errors++;
            $display("FAIL done_flags[%0d] busy=%b in_ready=%b state=%0d want 1 0 2",
                     g, busy[g], in_ready[g], dbg[g]);
          end
          if (!seen[g]) begin
            seen[g] = 1'b1;
            checks++;
            if (acc_q[g].size() == 0) begin
              errors++;
              $display("FAIL spurious_out[%0d] out_valid=1 want no pending op", g);
            end else if (cyc - acc_q[g][0] != lat[g]) begin
              errors++;
              $display("FAIL latency[%0d] got %0d want %0d", g, cyc - acc_q[g][0], lat[g]);
            end
          end
          if (out_ready) begin
            checks++;
            if (exp_q[g].size() == 0) begin
              errors++;
              $display("FAIL result_unexpected[%0d] y=%b", g, y[g]);
            end else begin
              if (y[g] !== exp_q[g][0]) begin
                errors++;
                $display("FAIL result[%0d] y=%b want %b", g, y[g], exp_q[g][0]);
              end
              void'(exp_q[g].pop_front());
              if (acc_q[g].size() != 0) void'(acc_q[g].pop_front());
            end
            seen[g]     = 1'b0;
            chk_idle[g] = 1'b1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string name);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (in_ready[g] !== 1'b1 || out_valid[g] !== 1'b0 || y[g] !== 1'b0 || busy[g] !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d] in_ready/out_valid/y/busy=%b%b%b%b want 1000",
                 name, g, in_ready[g], out_valid[g], y[g], busy[g]);
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (in_ready !== 3'b111 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 3'b111) begin
      errors++;
      $display("FAIL wait_idle_timeout in_ready=%b want 111", in_ready);
    end
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [1:0] mv, input logic ev);
    wait_idle();
    a        = av;
    mode     = mv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      exp_q[g].push_back(ev);
      acc_q[g].push_back(cyc);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d/%0d/%0d want 0/0/0",
               exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
    end
  endtask

  logic [W-1:0] vec_a [10] = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000, 16'h0007,
                               16'h0007, 16'h1234, 16'h1234, 16'hFFFF, 16'hA5A5};
  logic [1:0]   vec_m [10] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10,
                               2'b11, 2'b10, 2'b11, 2'b10, 2'b01};
  logic         vec_e [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                               1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [W-1:0] ra;
    logic [1:0]   rm;
    int n;

    // Asynchronous reset assertion before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_outs("reset_async");
    step();
    step();
    check_reset_outs("reset_held");
    rst_n = 1'b1;
    step();

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) issue(vec_a[i], vec_m[i], vec_e[i]);
    drain();

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rm = 2'($urandom_range(0, 3));
      issue(ra, rm, ref_red(ra, rm));
    end
    drain();

    // Backpressure in DONE while the inputs wander.
    out_ready = 1'b0;
    issue(16'h00F0, 2'b01, 1'b1);
    n = 0;
    while (out_valid !== 3'b111 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (out_valid !== 3'b111) begin
      errors++;
      $display("FAIL hold_reach_done out_valid=%b want 111", out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 3'b111 || busy !== 3'b111 || in_ready !== 3'b000 || y !== 3'b111) begin
        errors++;
        $display("FAIL hold[%0d] out_valid=%b busy=%b in_ready=%b y=%b want 111 111 000 111",
                 i, out_valid, busy, in_ready, y);
      end
      a        = 16'($urandom);
      mode     = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 3'b111 || busy !== 3'b000) begin
      errors++;
      $display("FAIL hold_release in_ready=%b busy=%b want 111 000", in_ready, busy);
    end
    drain();

    // Reset in the second RUN cycle discards the operation.
    out_ready = 1'b1;
    issue(16'h0000, 2'b00, 1'b0);
    step();
    #1 rst_n = 1'b0;
    #1 check_reset_outs("reset_mid_run");
    for (int g = 0; g < 3; g++) begin
      exp_q[g].delete();
      acc_q[g].delete();
    end
    step();
    rst_n = 1'b1;
    step();
    check_reset_outs("after_release");
    issue(16'hFFFF, 2'b00, 1'b1);
    drain();

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
